riscv_core_lsu: RTL and testbench

Load/store unit directly downstream of the execute-stage ALU. It consumes the ALU result as the effective address, together with rs2 store data and funct3. It issues one naturally aligned 64-bit-wide request to the data-memory port, then returns the load data sign- or zero-extended to XLEN. It stalls the pipeline through o_lsu_busy while an access is in flight.

---
 rtl/riscv_core_pkg.sv | 38 +++
 rtl/riscv_core_lsu_align.sv | 50 +++++
 rtl/riscv_core_lsu_chk.sv | 22 ++
 rtl/riscv_core_lsu.sv | 212 +++++++++++++++++++++
 tb/tb_riscv_core_lsu.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_core_pkg.sv
// Shared LSU definitions: FSM states, funct3 size encodings and request legality check.
package riscv_core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        FAULT = 2'd3
    } lsu_state_e;

    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_D  = 3'b011,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101,
        LSU_WU = 3'b110
    } lsu_size_e;

    localparam int WSTRB_W = 8;

    // Misaligned for its size, or a size that does not exist for this direction.
    function automatic logic lsu_req_bad(input logic we, input logic [2:0] funct3, input logic [2:0] off);
        logic misaligned;
        logic illegal;
        case (funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off[1:0] != 2'b00);
            2'b11:   misaligned = (off != 3'b000);
            default: misaligned = 1'b0;
        endcase
        illegal = we ? funct3[2] : (funct3 == 3'b111);
        return misaligned | illegal;
    endfunction

endpackage

// File: rtl/riscv_core_lsu_align.sv
// Combinational lane steering: store data/strobe placement and load byte extract + extend.
module riscv_core_lsu_align
    import riscv_core_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]         st_funct3,
    input  logic [2:0]         st_off,
    input  logic [XLEN-1:0]    st_wdata,
    output logic [XLEN-1:0]    st_lane_wdata,
    output logic [WSTRB_W-1:0] st_lane_wstrb,
    input  logic [2:0]         ld_funct3,
    input  logic [2:0]         ld_off,
    input  logic [XLEN-1:0]    ld_rdata,
    output logic [XLEN-1:0]    ld_data
);

    logic [XLEN-1:0] ld_shift_s;

    assign st_lane_wdata = st_wdata << {st_off, 3'b000};
    assign ld_shift_s    = ld_rdata >> {ld_off, 3'b000};

    // Store strobes; illegal store sizes get no enables
    always_comb begin
        st_lane_wstrb = 8'h00;
        case (st_funct3)
            LSU_B:   st_lane_wstrb = 8'h01 << st_off;
            LSU_H:   st_lane_wstrb = 8'h03 << st_off;
            LSU_W:   st_lane_wstrb = 8'h0F << st_off;
            LSU_D:   st_lane_wstrb = 8'hFF;
            default: st_lane_wstrb = 8'h00;
        endcase
    end

    // Load extraction with sign or zero extension
    always_comb begin
        ld_data = {XLEN{1'b0}};
        case (ld_funct3)
            LSU_B:   ld_data = {{(XLEN-8){ld_shift_s[7]}}, ld_shift_s[7:0]};
            LSU_H:   ld_data = {{(XLEN-16){ld_shift_s[15]}}, ld_shift_s[15:0]};
            LSU_W:   ld_data = {{(XLEN-32){ld_shift_s[31]}}, ld_shift_s[31:0]};
            LSU_D:   ld_data = ld_shift_s;
            LSU_BU:  ld_data = {{(XLEN-8){1'b0}}, ld_shift_s[7:0]};
            LSU_HU:  ld_data = {{(XLEN-16){1'b0}}, ld_shift_s[15:0]};
            LSU_WU:  ld_data = {{(XLEN-32){1'b0}}, ld_shift_s[31:0]};
            default: ld_data = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/riscv_core_lsu_chk.sv
// Protocol checker for riscv_core_lsu; instantiate alongside the LSU in simulation.
module riscv_core_lsu_chk (
    input logic i_clk,
    input logic i_rst,
    input logic i_lsu_valid,
    input logic o_lsu_busy,
    input logic o_lsu_done,
    input logic o_lsu_fault,
    input logic o_mem_req
);

    // Upstream must hold off while an access is in flight
    a_no_valid_when_busy: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_lsu_valid && o_lsu_busy));

    a_fault_with_done: assert property (@(posedge i_clk) disable iff (i_rst)
        !o_lsu_fault || o_lsu_done);

    a_req_implies_busy: assert property (@(posedge i_clk) disable iff (i_rst)
        !o_mem_req || o_lsu_busy);

endmodule

// File: rtl/riscv_core_lsu.sv
// Load/store unit: one aligned doubleword memory request per access, extended load return.
// Optional request/response watchdog enabled by defining RISCV_LSU_TIMEOUT_EN.
module riscv_core_lsu
    import riscv_core_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_lsu_valid,
    input  logic               i_lsu_we,
    input  logic [2:0]         i_lsu_funct3,
    input  logic [XLEN-1:0]    i_lsu_addr,
    input  logic [XLEN-1:0]    i_lsu_wdata,
    output logic               o_lsu_busy,
    output logic               o_lsu_done,
    output logic               o_lsu_fault,
    output logic [XLEN-1:0]    o_lsu_rdata,
    output logic               o_mem_req,
    output logic               o_mem_we,
    output logic [XLEN-1:0]    o_mem_addr,
    output logic [XLEN-1:0]    o_mem_wdata,
    output logic [WSTRB_W-1:0] o_mem_wstrb,
    input  logic               i_mem_gnt,
    input  logic               i_mem_rvalid,
    input  logic [XLEN-1:0]    i_mem_rdata
);

    lsu_state_e         state_r;
    lsu_state_e         state_n;
    logic               we_r;
    logic [2:0]         funct3_r;
    logic [2:0]         off_r;
    logic [XLEN-1:0]    mem_addr_r;
    logic [XLEN-1:0]    mem_wdata_r;
    logic [WSTRB_W-1:0] mem_wstrb_r;
    logic               mem_req_r;
    logic               busy_r;
    logic               done_r;
    logic               fault_r;
    logic [XLEN-1:0]    rdata_r;

    logic               accept_s;
    logic               bad_s;
    logic               timeout_s;
    logic               done_s;
    logic               fault_s;
    logic               rdata_load_s;
    logic [XLEN-1:0]    st_lane_wdata_s;
    logic [WSTRB_W-1:0] st_lane_wstrb_s;
    logic [XLEN-1:0]    ld_data_s;

    assign accept_s = (state_r == IDLE) && i_lsu_valid;
    assign bad_s    = lsu_req_bad(i_lsu_we, i_lsu_funct3, i_lsu_addr[2:0]);

    riscv_core_lsu_align #(.XLEN(XLEN)) u_align (
        .st_funct3     (i_lsu_funct3),
        .st_off        (i_lsu_addr[2:0]),
        .st_wdata      (i_lsu_wdata),
        .st_lane_wdata (st_lane_wdata_s),
        .st_lane_wstrb (st_lane_wstrb_s),
        .ld_funct3     (funct3_r),
        .ld_off        (off_r),
        .ld_rdata      (i_mem_rdata),
        .ld_data       (ld_data_s)
    );

`ifdef RISCV_LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] tmo_cnt_r;

    // Watchdog restarts on every state change and counts while REQ/WAIT persist
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else if (state_n != state_r) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == REQ) || (state_r == WAIT)) begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    assign timeout_s = ((state_r == REQ) || (state_r == WAIT)) &&
                       (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_timeout_cycles_s;
    assign unused_timeout_cycles_s = TIMEOUT_CYCLES;
    assign timeout_s               = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next-state; gnt/rvalid take priority over a same-cycle watchdog expiry
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (i_lsu_valid) begin
                    state_n = bad_s ? FAULT : REQ;
                end else begin
                    state_n = IDLE;
                end
            end
            REQ: begin
                if (i_mem_gnt) begin
                    state_n = we_r ? IDLE : WAIT;
                end else if (timeout_s) begin
                    state_n = FAULT;
                end else begin
                    state_n = REQ;
                end
            end
            WAIT: begin
                if (i_mem_rvalid) begin
                    state_n = IDLE;
                end else if (timeout_s) begin
                    state_n = FAULT;
                end else begin
                    state_n = WAIT;
                end
            end
            FAULT:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // FSM output decode: completion events feeding the registered outputs
    always_comb begin
        done_s       = 1'b0;
        fault_s      = 1'b0;
        rdata_load_s = 1'b0;
        case (state_r)
            REQ: begin
                done_s = i_mem_gnt && we_r;
            end
            WAIT: begin
                done_s       = i_mem_rvalid;
                rdata_load_s = i_mem_rvalid;
            end
            FAULT: begin
                done_s  = 1'b1;
                fault_s = 1'b1;
            end
            default: begin
                done_s = 1'b0;
            end
        endcase
    end

    // Output and request registers; request fields are frozen at accept
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mem_req_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            fault_r     <= 1'b0;
            rdata_r     <= {XLEN{1'b0}};
            we_r        <= 1'b0;
            funct3_r    <= 3'b000;
            off_r       <= 3'b000;
            mem_addr_r  <= {XLEN{1'b0}};
            mem_wdata_r <= {XLEN{1'b0}};
            mem_wstrb_r <= {WSTRB_W{1'b0}};
        end else begin
            mem_req_r <= (state_n == REQ);
            busy_r    <= (state_n != IDLE);
            done_r    <= done_s;
            fault_r   <= fault_s;
            if (rdata_load_s) begin
                rdata_r <= ld_data_s;
            end else begin
                rdata_r <= rdata_r;
            end
            if (accept_s) begin
                we_r        <= i_lsu_we;
                funct3_r    <= i_lsu_funct3;
                off_r       <= i_lsu_addr[2:0];
                mem_addr_r  <= {i_lsu_addr[XLEN-1:3], 3'b000};
                mem_wdata_r <= st_lane_wdata_s;
                mem_wstrb_r <= st_lane_wstrb_s;
            end else begin
                we_r        <= we_r;
                funct3_r    <= funct3_r;
                off_r       <= off_r;
                mem_addr_r  <= mem_addr_r;
                mem_wdata_r <= mem_wdata_r;
                mem_wstrb_r <= mem_wstrb_r;
            end
        end
    end

    assign o_lsu_busy  = busy_r;
    assign o_lsu_done  = done_r;
    assign o_lsu_fault = fault_r;
    assign o_lsu_rdata = rdata_r;
    assign o_mem_req   = mem_req_r;
    assign o_mem_we    = we_r;
    assign o_mem_addr  = mem_addr_r;
    assign o_mem_wdata = mem_wdata_r;
    assign o_mem_wstrb = mem_wstrb_r;

endmodule

// File: tb/tb_riscv_core_lsu.sv
// Self-checking bench for riscv_core_lsu: directed table, reset/timeout sequences, random ops vs model.
module tb_riscv_core_lsu;

    localparam int TB_TIMEOUT = 4;

    logic        i_clk;
    logic        i_rst;
    logic        i_lsu_valid;
    logic        i_lsu_we;
    logic [2:0]  i_lsu_funct3;
    logic [63:0] i_lsu_addr;
    logic [63:0] i_lsu_wdata;
    logic        o_lsu_busy;
    logic        o_lsu_done;
    logic        o_lsu_fault;
    logic [63:0] o_lsu_rdata;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [63:0] o_mem_addr;
    logic [63:0] o_mem_wdata;
    logic [7:0]  o_mem_wstrb;
    logic        i_mem_gnt;
    logic        i_mem_rvalid;
    logic [63:0] i_mem_rdata;

    riscv_core_lsu #(.XLEN(64), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_lsu_valid(i_lsu_valid), .i_lsu_we(i_lsu_we),
        .i_lsu_funct3(i_lsu_funct3), .i_lsu_addr(i_lsu_addr), .i_lsu_wdata(i_lsu_wdata),
        .o_lsu_busy(o_lsu_busy), .o_lsu_done(o_lsu_done), .o_lsu_fault(o_lsu_fault),
        .o_lsu_rdata(o_lsu_rdata), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
        .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
    );

    riscv_core_lsu_chk u_chk (
        .i_clk(i_clk), .i_rst(i_rst), .i_lsu_valid(i_lsu_valid), .o_lsu_busy(o_lsu_busy),
        .o_lsu_done(o_lsu_done), .o_lsu_fault(o_lsu_fault), .o_mem_req(o_mem_req)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          gdly;
        int          rdly;
        logic [63:0] mrd;
        logic        efault;
        logic [7:0]  estrb;
        logic [63:0] ewd;
        logic [63:0] erd;
    } vec_t;

    vec_t        vecs [15];
    int          tests = 0;
    int          fails = 0;
    logic [63:0] model_rdata;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model computed directly from the size/offset rules
    task automatic model_op(inout vec_t v, input logic [63:0] prev);
        int          nbytes;
        int          off;
        int          s;
        logic [63:0] sh;
        logic [63:0] mask;
        nbytes   = 1 << v.f3[1:0];
        off      = int'(v.addr % 8);
        v.efault = ((v.addr % nbytes) != 0) || (!v.we && v.f3 == 3'd7) || (v.we && v.f3 >= 3'd4);
        v.ewd    = v.wdata << (8 * off);
        s        = ((1 << nbytes) - 1) << off;
        v.estrb  = s[7:0];
        v.erd    = prev;
        if (!v.efault && !v.we) begin
            sh = v.mrd >> (8 * off);
            if (nbytes == 8) begin
                v.erd = sh;
            end else begin
                mask  = (64'd1 << (8 * nbytes)) - 64'd1;
                v.erd = sh & mask;
                if (v.f3 < 3'd4 && v.erd[8*nbytes-1]) v.erd = v.erd | ~mask;
            end
        end
    endtask

    // Issue one request at the current negedge and respond as a memory would
    task automatic run_op(input vec_t v, input string name);
        int   cyc;
        int   reqn;
        int   waitn;
        int   elat;
        logic granted;
        logic got;
        i_lsu_valid  = 1'b1;
        i_lsu_we     = v.we;
        i_lsu_funct3 = v.f3;
        i_lsu_addr   = v.addr;
        i_lsu_wdata  = v.wdata;
        @(posedge i_clk);
        @(negedge i_clk);
        i_lsu_valid = 1'b0;
        i_lsu_addr  = {$urandom, $urandom};
        i_lsu_wdata = {$urandom, $urandom};
        cyc = 1; reqn = 0; waitn = 0; granted = 1'b0; got = 1'b0;
        elat = v.efault ? 2 : (v.we ? v.gdly + 2 : v.gdly + v.rdly + 3);
        while (!got && cyc < 60) begin
            if (o_lsu_done) begin
                got = 1'b1;
            end else begin
                chk({name, "/busy"}, 64'(o_lsu_busy), 64'd1);
                i_mem_gnt    = 1'b0;
                i_mem_rvalid = 1'b0;
                i_mem_rdata  = {$urandom, $urandom};
                if (v.efault) begin
                    chk({name, "/no_req"}, 64'(o_mem_req), 64'd0);
                end else if (!granted) begin
                    chk({name, "/req"}, 64'(o_mem_req), 64'd1);
                    chk({name, "/we"}, 64'(o_mem_we), 64'(v.we));
                    chk({name, "/addr"}, o_mem_addr, v.addr & ~64'h7);
                    if (v.we) begin
                        chk({name, "/wstrb"}, 64'(o_mem_wstrb), 64'(v.estrb));
                        chk({name, "/wdata"}, o_mem_wdata, v.ewd);
                    end
                    if (reqn == v.gdly) begin
                        i_mem_gnt = 1'b1;
                        granted   = 1'b1;
                    end else begin
                        i_mem_rvalid = 1'($urandom % 2);
                    end
                    reqn++;
                end else begin
                    chk({name, "/wait_noreq"}, 64'(o_mem_req), 64'd0);
                    if (waitn == v.rdly) begin
                        i_mem_rvalid = 1'b1;
                        i_mem_rdata  = v.mrd;
                    end else begin
                        i_mem_gnt = 1'($urandom % 2);
                    end
                    waitn++;
                end
                @(posedge i_clk);
                @(negedge i_clk);
                cyc++;
            end
        end
        i_mem_gnt    = 1'b0;
        i_mem_rvalid = 1'b0;
        if (!got) begin
            chk({name, "/done_timeout"}, 64'd0, 64'd1);
        end else begin
            chk({name, "/latency"}, 64'(cyc), 64'(elat));
            chk({name, "/fault"}, 64'(o_lsu_fault), 64'(v.efault));
            chk({name, "/rdata"}, o_lsu_rdata, v.erd);
            chk({name, "/idle_busy"}, 64'(o_lsu_busy), 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 3'd3, 64'h1000, 64'h1122334455667788, 0, 0, 64'h0, 1'b0, 8'hFF, 64'h1122334455667788, 64'h0};
        vecs[1]  = '{1'b1, 3'd2, 64'h1004, 64'hDEADBEEF, 0, 0, 64'h0, 1'b0, 8'hF0, 64'hDEADBEEF_00000000, 64'h0};
        vecs[2]  = '{1'b0, 3'd0, 64'h1003, 64'h0, 0, 0, 64'h00000000_80000000, 1'b0, 8'h00, 64'h0, 64'hFFFFFFFFFFFFFF80};
        vecs[3]  = '{1'b0, 3'd4, 64'h1003, 64'h0, 0, 0, 64'h00000000_80000000, 1'b0, 8'h00, 64'h0, 64'h0000000000000080};
        vecs[4]  = '{1'b0, 3'd2, 64'h1002, 64'h0, 0, 0, 64'h0, 1'b1, 8'h00, 64'h0, 64'h0000000000000080};
        vecs[5]  = '{1'b0, 3'd7, 64'h1000, 64'h0, 0, 0, 64'h0, 1'b1, 8'h00, 64'h0, 64'h0000000000000080};
        vecs[6]  = '{1'b1, 3'd3, 64'h2008, 64'hA5A5A5A55A5A5A5A, 3, 0, 64'h0, 1'b0, 8'hFF, 64'hA5A5A5A55A5A5A5A, 64'h0000000000000080};
        vecs[7]  = '{1'b0, 3'd1, 64'h2006, 64'h0, 2, 3, 64'h8123000000000000, 1'b0, 8'h00, 64'h0, 64'hFFFFFFFFFFFF8123};
        vecs[8]  = '{1'b0, 3'd6, 64'h2004, 64'h0, 1, 1, 64'hF000000000000000, 1'b0, 8'h00, 64'h0, 64'h00000000F0000000};
        vecs[9]  = '{1'b0, 3'd3, 64'h2000, 64'h0, 0, 2, 64'h0123456789ABCDEF, 1'b0, 8'h00, 64'h0, 64'h0123456789ABCDEF};
        vecs[10] = '{1'b1, 3'd0, 64'h3005, 64'hFFFFFFFFFFFFFFAB, 1, 0, 64'h0, 1'b0, 8'h20, 64'hFFFFAB0000000000, 64'h0123456789ABCDEF};
        vecs[11] = '{1'b1, 3'd1, 64'h3006, 64'h1234, 0, 0, 64'h0, 1'b0, 8'hC0, 64'h1234000000000000, 64'h0123456789ABCDEF};
        vecs[12] = '{1'b1, 3'd4, 64'h3000, 64'h55, 0, 0, 64'h0, 1'b1, 8'h00, 64'h0, 64'h0123456789ABCDEF};
        vecs[13] = '{1'b1, 3'd1, 64'h3001, 64'h77, 0, 0, 64'h0, 1'b1, 8'h00, 64'h0, 64'h0123456789ABCDEF};
        vecs[14] = '{1'b0, 3'd2, 64'h3004, 64'h0, 0, 0, 64'h80000000_00000000, 1'b0, 8'h00, 64'h0, 64'hFFFFFFFF80000000};

        i_rst = 1'b1; i_lsu_valid = 1'b0; i_lsu_we = 1'b0; i_lsu_funct3 = 3'd0;
        i_lsu_addr = 64'h0; i_lsu_wdata = 64'h0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 64'h0;
        repeat (3) @(negedge i_clk);
        chk("rst/busy", 64'(o_lsu_busy), 64'd0);
        chk("rst/done", 64'(o_lsu_done), 64'd0);
        chk("rst/fault", 64'(o_lsu_fault), 64'd0);
        chk("rst/rdata", o_lsu_rdata, 64'd0);
        chk("rst/req", 64'(o_mem_req), 64'd0);
        chk("rst/we", 64'(o_mem_we), 64'd0);
        chk("rst/addr", o_mem_addr, 64'd0);
        chk("rst/wdata", o_mem_wdata, 64'd0);
        chk("rst/wstrb", 64'(o_mem_wstrb), 64'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("post_rst/busy", 64'(o_lsu_busy), 64'd0);

        for (int i = 0; i < 15; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // Reset while waiting for load data; late rvalid must be ignored
        i_lsu_valid = 1'b1; i_lsu_we = 1'b0; i_lsu_funct3 = 3'd3; i_lsu_addr = 64'h4000;
        @(posedge i_clk); @(negedge i_clk);
        i_lsu_valid = 1'b0; i_mem_gnt = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        i_mem_gnt = 1'b0;
        chk("rstwait/busy_before", 64'(o_lsu_busy), 64'd1);
        chk("rstwait/req_before", 64'(o_mem_req), 64'd0);
        i_rst = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        i_rst = 1'b0;
        chk("rstwait/busy", 64'(o_lsu_busy), 64'd0);
        chk("rstwait/rdata", o_lsu_rdata, 64'd0);
        chk("rstwait/addr", o_mem_addr, 64'd0);
        i_mem_rvalid = 1'b1; i_mem_gnt = 1'b1; i_mem_rdata = 64'hCAFEBABE12345678;
        @(posedge i_clk); @(negedge i_clk);
        i_mem_rvalid = 1'b0; i_mem_gnt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rstwait/nodone%0d", k), 64'(o_lsu_done), 64'd0);
            chk($sformatf("rstwait/idle%0d", k), 64'(o_lsu_busy), 64'd0);
            chk($sformatf("rstwait/rdata%0d", k), o_lsu_rdata, 64'd0);
            @(negedge i_clk);
        end

        // Store that never sees a grant
        i_lsu_valid = 1'b1; i_lsu_we = 1'b1; i_lsu_funct3 = 3'd3; i_lsu_addr = 64'h5000; i_lsu_wdata = 64'h1;
        @(posedge i_clk); @(negedge i_clk);
        i_lsu_valid = 1'b0;
`ifdef RISCV_LSU_TIMEOUT_EN
        for (int k = 1; k <= TB_TIMEOUT; k++) begin
            chk($sformatf("tmo/req%0d", k), 64'(o_mem_req), 64'd1);
            chk($sformatf("tmo/nodone%0d", k), 64'(o_lsu_done), 64'd0);
            @(negedge i_clk);
        end
        chk("tmo/fault_state_req", 64'(o_mem_req), 64'd0);
        chk("tmo/fault_state_busy", 64'(o_lsu_busy), 64'd1);
        @(negedge i_clk);
        chk("tmo/done", 64'(o_lsu_done), 64'd1);
        chk("tmo/fault", 64'(o_lsu_fault), 64'd1);
        chk("tmo/busy", 64'(o_lsu_busy), 64'd0);
        chk("tmo/rdata", o_lsu_rdata, 64'd0);
`else
        for (int k = 1; k <= 20; k++) begin
            chk($sformatf("nogtn/req%0d", k), 64'(o_mem_req), 64'd1);
            chk($sformatf("nognt/nodone%0d", k), 64'(o_lsu_done), 64'd0);
            @(negedge i_clk);
        end
        i_mem_gnt = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        i_mem_gnt = 1'b0;
        chk("nognt/done", 64'(o_lsu_done), 64'd1);
        chk("nognt/fault", 64'(o_lsu_fault), 64'd0);
        chk("nognt/busy", 64'(o_lsu_busy), 64'd0);
`endif

        model_rdata = 64'd0;
        for (int n = 0; n < 150; n++) begin
            vec_t v;
            int   nb;
            v.we    = 1'($urandom % 2);
            v.f3    = 3'($urandom % 8);
            v.addr  = {$urandom, $urandom};
            nb      = 1 << v.f3[1:0];
            if ($urandom % 4 != 0) v.addr = v.addr & ~64'(nb - 1);
            v.wdata = {$urandom, $urandom};
            v.mrd   = {$urandom, $urandom};
            v.gdly  = int'($urandom % 4);
            v.rdly  = int'($urandom % 4);
            model_op(v, model_rdata);
            model_rdata = v.erd;
            run_op(v, $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
